// File: rtl/demux_rr_dispatcher.sv
// Round-robin 1:4 dispatcher: steers a valid/ready stream to four channels,
// BURST words per channel, through a single-entry output register.
module demux_rr_dispatcher #(
  parameter int DATA_W = 8,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [3:0]        chan_en,
  input  logic [3:0]        out_ready,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        sel
);

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_sel;
  logic              r_valid;
  logic [1:0]        r_cur;
  logic [CNT_W-1:0]  r_cnt;

  logic       w_drain;
  logic       w_in_ready;
  logic       w_load;
  logic       w_any_en;
  logic       w_found;
  logic [1:0] w_idx;
  logic [1:0] w_next_cur;

  assign w_drain    = r_valid & out_ready[r_sel];
  // Gated by rst so the upstream never sees a handshake while reset is held.
  assign w_in_ready = ~rst & chan_en[r_cur] & (~r_valid | w_drain);
  assign w_load     = in_valid & w_in_ready;
  assign w_any_en   = |chan_en;

  // First enabled channel in the order cur+1, cur+2, cur+3, cur; holds if none.
  always_comb begin
    w_next_cur = r_cur;
    w_found    = 1'b0;
    w_idx      = r_cur;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_idx = r_cur + 2'(k);
      if (!w_found && chan_en[w_idx]) begin
        w_next_cur = w_idx;
        w_found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_cur   <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_data  <= in_data;
      r_sel   <= r_cur;
      r_valid <= 1'b1;
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_cur <= w_next_cur;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      if (w_drain) begin
        r_valid <= 1'b0;
      end
      // Skip past a disabled channel; with nothing enabled, cur and cnt hold.
      if (!chan_en[r_cur] && w_any_en) begin
        r_cur <= w_next_cur;
        r_cnt <= '0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid ? (4'b0001 << r_sel) : 4'b0000;
  assign out_data  = r_data;
  assign sel       = r_sel;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Bench for demux_rr_dispatcher: directed scenarios plus random traffic,
// checked each cycle against a transaction-level model of the dispatcher.
module tb_demux_rr_dispatcher;

  localparam int DW = 8;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [3:0]    chan_en = 4'b0000;
  logic [3:0]    out_ready = 4'b0000;
  logic [3:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    sel;

  demux_rr_dispatcher #(.DATA_W(DW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .chan_en(chan_en), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .sel(sel)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: held word (valid, data, channel), next channel and words sent to it.
  bit          m_valid;
  logic [DW-1:0] m_data;
  int          m_chan;
  int          m_cur;
  int          m_cnt;

  // Words observed leaving the DUT, per channel.
  logic [DW-1:0] got[4][$];

  function automatic logic [14:0] exp_vec();
    logic rdy;
    logic [3:0] ov;
    rdy = !rst && chan_en[m_cur] && (!m_valid || out_ready[m_chan]);
    ov  = m_valid ? 4'(1 << m_chan) : 4'b0000;
    return {rdy, ov, 2'(m_chan), m_data};
  endfunction

  function automatic int next_enabled(int from);
    int n = from;
    bit found = 0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && chan_en[(from + k) % 4]) begin
        n = (from + k) % 4;
        found = 1;
      end
    end
    return n;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_chan = 0; m_cur = 0; m_cnt = 0;
    foreach (got[c]) got[c].delete();
  endtask

  // Record DUT deliveries, take the clock edge, update the model.
  task automatic advance();
    bit drain, load;
    for (int c = 0; c < 4; c++)
      if (out_valid[c] && out_ready[c]) got[c].push_back(out_data);
    @(posedge clk);
    if (!rst) begin
      drain = m_valid && out_ready[m_chan];
      load  = in_valid && chan_en[m_cur] && (!m_valid || drain);
      if (load) begin
        m_data = in_data; m_chan = m_cur; m_valid = 1;
        m_cnt++;
        if (m_cnt == BURST) begin
          m_cnt = 0;
          m_cur = next_enabled(m_cur);
        end
      end else begin
        if (drain) m_valid = 0;
        if (!chan_en[m_cur] && chan_en != 4'b0000) begin
          m_cur = next_enabled(m_cur);
          m_cnt = 0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [14:0] act, exp;
    do_reset();
    chan_en = 4'b1111; out_ready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i);
      #1;
      act = {in_ready, out_valid, sel, out_data}; exp = exp_vec(); total++;
      if (act !== exp) $display("FAIL reset_pre cyc %0d act=%h exp=%h", i, act, exp);
      else passed++;
      advance();
    end
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, sel, out_data} !== 15'h0)
      $display("FAIL reset_async act=%h exp=0", {in_ready, out_valid, sel, out_data});
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    in_valid = 1'b1; in_data = 8'h77;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready act=%b exp=1", in_ready);
    else passed++;
    advance();
    total++;
    if ({out_valid, sel, out_data} !== {4'b0001, 2'd0, 8'h77})
      $display("FAIL reset_cur0 act=%b/%0d/%h exp=0001/0/77", out_valid, sel, out_data);
    else passed++;
  endtask

  task automatic test_rotation();
    logic [14:0] act, exp;
    bit ok;
    do_reset();
    chan_en = 4'b1111; out_ready = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      act = {in_ready, out_valid, sel, out_data}; exp = exp_vec(); total++;
      if (act !== exp || in_ready !== 1'b1)
        $display("FAIL rotation cyc %0d act=%h exp=%h", i, act, exp);
      else passed++;
      advance();
    end
    in_valid = 1'b0;
    advance(); advance();
    for (int c = 0; c < 4; c++) begin
      ok = (got[c].size() == 4);
      for (int j = 0; j < 4 && ok; j++) ok = (got[c][j] == 8'(4 * c + j));
      total++;
      if (!ok) $display("FAIL rotation_ch%0d got %0d words, first=%h exp %h..", c,
                        got[c].size(), (got[c].size() > 0) ? got[c][0] : 8'hxx, 8'(4 * c));
      else passed++;
    end
  endtask

  task automatic test_skip();
    logic [14:0] act, exp;
    bit ok;
    do_reset();
    chan_en = 4'b0101; out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      act = {in_ready, out_valid, sel, out_data}; exp = exp_vec(); total++;
      if (act !== exp || out_valid[1] || out_valid[3])
        $display("FAIL skip cyc %0d act=%h exp=%h", i, act, exp);
      else passed++;
      advance();
    end
    in_valid = 1'b0;
    advance(); advance();
    ok = got[0].size() == 4 && got[2].size() == 4 && got[1].size() == 0 && got[3].size() == 0;
    for (int j = 0; j < 4 && ok; j++) ok = (got[0][j] == 8'(j)) && (got[2][j] == 8'(4 + j));
    total++;
    if (!ok) $display("FAIL skip_delivery sizes act=%0d/%0d/%0d/%0d exp=4/0/4/0",
                      got[0].size(), got[1].size(), got[2].size(), got[3].size());
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [14:0] act, exp;
    do_reset();
    chan_en = 4'b1111; out_ready = 4'b1110;
    in_valid = 1'b1; in_data = 8'hA5;
    advance();
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h5A;
      #1;
      act = {in_ready, out_valid, sel, out_data}; exp = exp_vec(); total++;
      if (act !== exp || out_data !== 8'hA5 || in_ready !== 1'b0)
        $display("FAIL backpressure cyc %0d act=%h exp=%h", i, act, exp);
      else passed++;
      advance();
    end
    out_ready = 4'b1111;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready act=%b exp=1", in_ready);
    else passed++;
    advance();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_data} !== {4'b0001, 8'h5A} || got[0].size() != 1)
      $display("FAIL bp_release_load act=%b/%h exp=0001/5a", out_valid, out_data);
    else passed++;
    advance();
  endtask

  task automatic test_disable();
    logic [14:0] act, exp;
    bit ok;
    do_reset();
    chan_en = 4'b1111; out_ready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      act = {in_ready, out_valid, sel, out_data}; exp = exp_vec(); total++;
      if (act !== exp) $display("FAIL disable_pre cyc %0d act=%h exp=%h", i, act, exp);
      else passed++;
      advance();
    end
    chan_en = 4'b1101; in_data = 8'd10;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 4'b0010 || out_data !== 8'd5)
      $display("FAIL disable_held act=%b/%b/%h exp=0/0010/05", in_ready, out_valid, out_data);
    else passed++;
    advance();
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(10 + i);
      #1;
      act = {in_ready, out_valid, sel, out_data}; exp = exp_vec(); total++;
      if (act !== exp) $display("FAIL disable_post cyc %0d act=%h exp=%h", i, act, exp);
      else passed++;
      advance();
    end
    in_valid = 1'b0;
    advance(); advance();
    ok = got[1].size() == 2 && got[2].size() == 4 && got[3].size() == 1;
    if (ok) ok = got[1][1] == 8'd5 && got[2][0] == 8'd10 && got[2][3] == 8'd13 && got[3][0] == 8'd14;
    total++;
    if (!ok) $display("FAIL disable_delivery sizes act=%0d/%0d/%0d exp=2/4/1",
                      got[1].size(), got[2].size(), got[3].size());
    else passed++;
  endtask

  task automatic test_all_disabled();
    logic [14:0] act, exp;
    do_reset();
    chan_en = 4'b1111; out_ready = 4'b0000;
    in_valid = 1'b1; in_data = 8'h3C;
    advance();
    chan_en = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      out_ready = (i >= 3) ? 4'b1111 : 4'b0000;
      in_data = 8'($urandom);
      #1;
      act = {in_ready, out_valid, sel, out_data}; exp = exp_vec(); total++;
      if (act !== exp || in_ready !== 1'b0 || (i >= 4 && out_valid !== 4'b0000))
        $display("FAIL all_disabled cyc %0d act=%h exp=%h", i, act, exp);
      else passed++;
      advance();
    end
    chan_en = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'hC0 + i);
      #1;
      act = {in_ready, out_valid, sel, out_data}; exp = exp_vec(); total++;
      if (act !== exp) $display("FAIL reenable cyc %0d act=%h exp=%h", i, act, exp);
      else passed++;
      advance();
    end
    in_valid = 1'b0;
    advance();
    total++;
    if (got[0].size() != 1 || got[0][0] !== 8'h3C || got[1].size() != 2)
      $display("FAIL all_disabled_delivery ch0=%0d ch1=%0d exp=1/2", got[0].size(), got[1].size());
    else passed++;
  endtask

  task automatic test_random();
    logic [14:0] act, exp;
    int errs = 0;
    do_reset();
    chan_en = 4'b1111;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) chan_en = 4'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      if ($urandom_range(0, 3) != 0) out_ready = out_ready | 4'(1 << m_chan);
      #1;
      act = {in_ready, out_valid, sel, out_data}; exp = exp_vec(); total++;
      if (act !== exp) begin
        if (errs < 10) $display("FAIL random cyc %0d act=%h exp=%h", i, act, exp);
        errs++;
      end else passed++;
      advance();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_skip();
    test_backpressure();
    test_disable();
    test_all_disabled();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
